pito_irq_evt_queue: RTL and testbench
=====================================

Name: pito_irq_evt_queue

Overview:
- Per-hart interrupt event buffer between the MVU interrupt sources and the per-hart CSR file.
- Accepts one `irq_evt_t` event per cycle and steers it into the FIFO of the addressed hart, of depth `IRQ_Q_DEPTH`.
- Raises that hart's MVU pending bit (the `MIP_MVIP` source) while its FIFO is non-empty, and exposes the head event's data.
- The CSR/trap logic pops one event per acknowledge.

Parameters:
- NUM_HARTS, pito_pkg::NUM_HARTS (8), number of harts / FIFOs.
- Q_DEPTH, pito_pkg::IRQ_Q_DEPTH (4), entries per hart FIFO; must be a power of 2, >= 2.
- DATA_W, 32, width of the event payload.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- irq_evt_i  in  $bits(irq_evt_t)  incoming event: {hart_id, data, valid}.
- irq_ack_i  in  NUM_HARTS  per-hart pop strobe from the CSR/trap logic (one-cycle pulse).
- mvu_irq_o  out  NUM_HARTS  per-hart pending flag; feeds MIP bit `IRQ_MVU_INTR`.
- irq_data_o  out  NUM_HARTS x DATA_W  head-of-queue payload per hart; 0 when empty.
- irq_ovf_o  out  NUM_HARTS  sticky per-hart overflow flag.
- irq_bad_hart_o  out  1  one-cycle pulse when a valid event targets hart_id >= NUM_HARTS.

Behaviour:
- Reset (async assert, sync-released by `clk`): all read/write pointers and counts cleared.
  - mvu_irq_o=0, irq_data_o=0, irq_ovf_o=0, irq_bad_hart_o=0.
  - Storage contents are don't-care.
- Push:
  - When irq_evt_i.valid=1 and hart_id < NUM_HARTS, the payload is written to FIFO[hart_id].
  - hart_id is HART_CNT_WIDTH+1 bits wide; any value >= NUM_HARTS is dropped and pulses irq_bad_hart_o on the next cycle.
- Latency:
  - Event accepted at edge N into an empty FIFO → mvu_irq_o[h]=1 and irq_data_o[h]=payload after edge N (visible in cycle N+1).
  - No combinational input→output path.
- Pop:
  - irq_ack_i[h]=1 with count>0 advances the read pointer.
  - irq_data_o[h] shows the next entry in the following cycle.
  - mvu_irq_o[h] deasserts the cycle after the last entry is popped.
  - Ack with count=0 is ignored, with no underflow and no pointer change.
- Per-hart count: 0..Q_DEPTH (width $clog2(Q_DEPTH)+1). Pointers are $clog2(Q_DEPTH) bits and wrap modulo Q_DEPTH.
- Full (count=Q_DEPTH):
  - A push without a same-cycle ack is dropped; irq_ovf_o[h] is set and stored data is unchanged.
  - Push and ack to the same full hart in the same cycle: both take effect; count stays Q_DEPTH; no overflow.
- Simultaneous push and ack on a non-full hart: both apply; count is unchanged.
  - With count=1 in this case, head data becomes the new payload next cycle and mvu_irq_o stays 1.
- irq_ovf_o[h] clears only on an ack to hart h that leaves its count at 0, i.e. a fully drained queue.
- Acks to different harts are independent and may all be asserted in one cycle.
- Reset mid-operation discards all queued events immediately.

Optional Feature:
- Macro: PITO_IRQ_DROP_CNT_EN.
- Defined:
  - Adds output irq_drop_cnt_o  NUM_HARTS x 8, a saturating per-hart count of dropped events (overflow drops only).
  - Saturates at 8'hFF and clears together with irq_ovf_o.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- pito_pkg already holds irq_evt_t, IRQ_Q_DEPTH, NUM_HARTS and IRQ_MVU_INTR.
- Add to pito_pkg:
  - `typedef logic [$clog2(IRQ_Q_DEPTH):0] irq_q_cnt_t`.
  - `localparam int unsigned IRQ_DROP_CNT_W = 8`.
- Sub-module pito_irq_fifo: a single-hart synchronous FIFO (push, pop, full, empty, head, count, simultaneous push/pop on full allowed).
  - Instantiated NUM_HARTS times through a generate loop.
  - The top level does hart decode, overflow/drop bookkeeping and output muxing.

Test Plan:
- Reset, then push {hart 2, 32'hDEAD_BEEF} → cycle+1: mvu_irq_o=8'b0000_0100, irq_data_o[2]=DEAD_BEEF; ack[2] → next cycle mvu_irq_o=0, irq_data_o[2]=0.
- Five back-to-back pushes to hart 0 (payloads 1..5), no ack → count=4, irq_ovf_o[0]=1, payload 5 lost; 4 acks return 1,2,3,4 in order; after the last ack irq_ovf_o[0]=0 and mvu_irq_o[0]=0.
- Hart 5 full (payloads A..D) with same-cycle push E plus ack → no overflow; head becomes B; drain order B,C,D,E.
- Push with hart_id=8 (4'b1000) → irq_bad_hart_o pulses 1 cycle; no mvu_irq_o bit changes.
- Interleaved pushes to harts 1 and 7 with simultaneous acks on both → independent ordering per hart; ack on empty hart 3 → no state change.
- Assert rst_n=0 mid-stream with 3 events queued on hart 4 → outputs zero asynchronously; after release, mvu_irq_o=0 until a new push.
- With PITO_IRQ_DROP_CNT_EN: 260 pushes to full hart 6 → irq_drop_cnt_o[6]=8'hFF (saturated); full drain clears it to 0.

Source files
------------

// File: rtl/pito_pkg.sv
// ==========================================================================
// pito_pkg : shared core types/constants, incl. IRQ event queue sizing
// Rev 1.0
// ==========================================================================
`default_nettype none

package pito_pkg;

  localparam int unsigned NUM_HARTS      = 8;
  localparam int unsigned HART_CNT_WIDTH = $clog2(NUM_HARTS);
  localparam int unsigned IRQ_Q_DEPTH    = 4;
  localparam int unsigned IRQ_MVU_INTR   = 16;
  localparam int unsigned IRQ_DROP_CNT_W = 8;

  // hart_id carries one extra bit so out-of-range targets are representable
  typedef struct packed {
    logic [HART_CNT_WIDTH:0] hart_id;
    logic [31:0]             data;
    logic                    valid;
  } irq_evt_t;

  typedef logic [$clog2(IRQ_Q_DEPTH):0] irq_q_cnt_t;

  function automatic logic [IRQ_DROP_CNT_W-1:0] sat_inc(input logic [IRQ_DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + IRQ_DROP_CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pito_irq_fifo.sv
// ==========================================================================
// pito_irq_fifo : single-hart synchronous FIFO; push on full is accepted
//                 only together with a pop. Rev 1.0
// ==========================================================================
`default_nettype none

module pito_irq_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      cnt <= cnt + CNT_W'(1);
      else if (!do_push && do_pop) cnt <= cnt - CNT_W'(1);
    end
  end

  // Storage needs no reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

`default_nettype wire

// File: rtl/pito_irq_evt_queue.sv
// ==========================================================================
// pito_irq_evt_queue : per-hart MVU interrupt event buffer feeding the CSRs.
// Optional drop counters under PITO_IRQ_DROP_CNT_EN. Rev 1.0
// ==========================================================================
`default_nettype none

module pito_irq_evt_queue #(
  parameter int unsigned NUM_HARTS = pito_pkg::NUM_HARTS,
  parameter int unsigned Q_DEPTH   = pito_pkg::IRQ_Q_DEPTH,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  pito_pkg::irq_evt_t                irq_evt_i,
  input  logic [NUM_HARTS-1:0]              irq_ack_i,
  output logic [NUM_HARTS-1:0]              mvu_irq_o,
  output logic [NUM_HARTS-1:0][DATA_W-1:0]  irq_data_o,
  output logic [NUM_HARTS-1:0]              irq_ovf_o,
  output logic                              irq_bad_hart_o
`ifdef PITO_IRQ_DROP_CNT_EN
  ,
  output logic [NUM_HARTS-1:0][pito_pkg::IRQ_DROP_CNT_W-1:0] irq_drop_cnt_o
`endif
);

  import pito_pkg::*;

  localparam int unsigned CNT_W = $clog2(Q_DEPTH) + 1;
  localparam int unsigned HID_W = HART_CNT_WIDTH + 1;

  logic              hart_ok;
  logic [DATA_W-1:0] din;
  logic              bad_hart;

  assign hart_ok = 32'(irq_evt_i.hart_id) < NUM_HARTS;
  assign din     = DATA_W'(irq_evt_i.data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bad_hart <= 1'b0;
    else        bad_hart <= irq_evt_i.valid && !hart_ok;
  end
  assign irq_bad_hart_o = bad_hart;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    logic              push;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] head;
    logic              drop;
    logic              drain;
    logic              ovf;

    assign push = irq_evt_i.valid && hart_ok && (irq_evt_i.hart_id == HID_W'(h));

    pito_irq_fifo #(
      .DEPTH  (Q_DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (irq_ack_i[h]),
      .din   (din),
      .head  (head),
      .count (cnt),
      .full  (full),
      .empty (empty)
    );

    // Drain means this ack removes the final entry with nothing refilling it
    assign drop  = push && full && !irq_ack_i[h];
    assign drain = irq_ack_i[h] && (cnt == CNT_W'(1)) && !push;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     ovf <= 1'b0;
      else if (drop)  ovf <= 1'b1;
      else if (drain) ovf <= 1'b0;
    end

`ifdef PITO_IRQ_DROP_CNT_EN
    logic [IRQ_DROP_CNT_W-1:0] drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     drop_cnt <= '0;
      else if (drop)  drop_cnt <= sat_inc(drop_cnt);
      else if (drain) drop_cnt <= '0;
    end
    assign irq_drop_cnt_o[h] = drop_cnt;
`endif

    assign mvu_irq_o[h]  = !empty;
    assign irq_data_o[h] = empty ? '0 : head;
    assign irq_ovf_o[h]  = ovf;
  end

endmodule

`default_nettype wire

// File: tb/tb_pito_irq_evt_queue.sv
// ==========================================================================
// tb_pito_irq_evt_queue : directed + randomized bench against a queue model
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_pito_irq_evt_queue;

  localparam int NH = 8;
  localparam int QD = 4;

  logic                 clk;
  logic                 rst_n;
  pito_pkg::irq_evt_t   evt;
  logic [NH-1:0]        ack;
  logic [NH-1:0]        mvu_irq;
  logic [NH-1:0][31:0]  irq_data;
  logic [NH-1:0]        irq_ovf;
  logic                 irq_bad_hart;
`ifdef PITO_IRQ_DROP_CNT_EN
  logic [NH-1:0][7:0]   irq_drop_cnt;
`endif

  pito_irq_evt_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .irq_evt_i      (evt),
    .irq_ack_i      (ack),
    .mvu_irq_o      (mvu_irq),
    .irq_data_o     (irq_data),
    .irq_ovf_o      (irq_ovf),
    .irq_bad_hart_o (irq_bad_hart)
`ifdef PITO_IRQ_DROP_CNT_EN
    ,
    .irq_drop_cnt_o (irq_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: one plain queue per hart plus flag bookkeeping
  logic [31:0] mq [NH][$];
  logic [NH-1:0] m_ovf;
  int            m_drop [NH];
  logic          m_badh;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int h = 0; h < NH; h++) begin
      mq[h].delete();
      m_drop[h] = 0;
    end
    m_ovf  = '0;
    m_badh = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [3:0] hid, input logic [31:0] d,
                            input logic [NH-1:0] a);
    for (int h = 0; h < NH; h++) begin
      bit pushing = v && (int'(hid) == h);
      bit popping = a[h] && (mq[h].size() > 0);
      if (pushing) begin
        if (mq[h].size() < QD || popping) mq[h].push_back(d);
        else begin
          m_ovf[h] = 1'b1;
          if (m_drop[h] < 255) m_drop[h]++;
        end
      end
      if (popping) begin
        void'(mq[h].pop_front());
        if (mq[h].size() == 0) begin
          m_ovf[h]  = 1'b0;
          m_drop[h] = 0;
        end
      end
    end
    m_badh = v && (int'(hid) >= NH);
  endtask

  task automatic compare_all();
    logic [NH-1:0] exp_mvu;
    for (int h = 0; h < NH; h++) begin
      exp_mvu[h] = (mq[h].size() > 0);
      check_eq($sformatf("data%0d", h), irq_data[h], (mq[h].size() > 0) ? mq[h][0] : 32'h0);
`ifdef PITO_IRQ_DROP_CNT_EN
      check_eq($sformatf("drop%0d", h), 32'(irq_drop_cnt[h]), 32'(m_drop[h]));
`endif
    end
    check_eq("mvu", 32'(mvu_irq), 32'(exp_mvu));
    check_eq("ovf", 32'(irq_ovf), 32'(m_ovf));
    check_eq("badh", 32'(irq_bad_hart), 32'(m_badh));
  endtask

  // One clock: drive, let the edge happen, advance model, sample 1ns later
  task automatic cyc(input logic v, input logic [3:0] hid, input logic [31:0] d,
                     input logic [NH-1:0] a);
    evt.valid   = v;
    evt.hart_id = hid;
    evt.data    = d;
    ack         = a;
    @(posedge clk);
    model_edge(v, hid, d, a);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 32'h0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    evt   = '0;
    ack   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // single event round trip on hart 2
    cyc(1'b1, 4'd2, 32'hDEAD_BEEF, '0);
    check_eq("tp1_mvu", 32'(mvu_irq), 32'h04);
    check_eq("tp1_data", irq_data[2], 32'hDEAD_BEEF);
    cyc(1'b0, 4'd0, 32'h0, 8'h04);
    check_eq("tp1_mvu_clr", 32'(mvu_irq), 32'h0);
    check_eq("tp1_data_clr", irq_data[2], 32'h0);

    // overflow on hart 0
    for (int i = 1; i <= 5; i++) cyc(1'b1, 4'd0, 32'(i), '0);
    check_eq("tp2_ovf", 32'(irq_ovf[0]), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      check_eq("tp2_order", irq_data[0], 32'(i));
      cyc(1'b0, 4'd0, 32'h0, 8'h01);
    end
    check_eq("tp2_ovf_clr", 32'(irq_ovf[0]), 32'h0);
    check_eq("tp2_mvu_clr", 32'(mvu_irq[0]), 32'h0);

    // push + ack on full hart 5
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'd5, 32'hA + 32'(i), '0);
    cyc(1'b1, 4'd5, 32'hE, 8'h20);
    check_eq("tp3_ovf", 32'(irq_ovf[5]), 32'h0);
    check_eq("tp3_head", irq_data[5], 32'hB);
    for (int i = 0; i < 4; i++) begin
      check_eq("tp3_order", irq_data[5], 32'hB + 32'(i));
      cyc(1'b0, 4'd0, 32'h0, 8'h20);
    end

    // out-of-range hart
    cyc(1'b1, 4'd8, 32'h1234, '0);
    check_eq("tp4_bad", 32'(irq_bad_hart), 32'h1);
    check_eq("tp4_mvu", 32'(mvu_irq), 32'h0);
    idle();
    check_eq("tp4_bad_pulse", 32'(irq_bad_hart), 32'h0);

    // interleaved harts 1/7 with joint acks, then ack on empty hart 3
    for (int i = 0; i < 6; i++) cyc(1'b1, (i % 2 == 0) ? 4'd1 : 4'd7, 32'h100 + 32'(i), '0);
    for (int i = 0; i < 4; i++) cyc(1'b1, (i % 2 == 0) ? 4'd7 : 4'd1, 32'h200 + 32'(i), 8'h82);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'd0, 32'h0, 8'h82);
    cyc(1'b0, 4'd0, 32'h0, 8'h08);

    // asynchronous reset with hart 4 loaded
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'd4, 32'h40 + 32'(i), '0);
    check_eq("tp6_pre", 32'(mvu_irq), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("tp6_mvu", 32'(mvu_irq), 32'h0);
    check_eq("tp6_data4", irq_data[4], 32'h0);
    check_eq("tp6_ovf", 32'(irq_ovf), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check_eq("tp6_post", 32'(mvu_irq), 32'h0);

`ifdef PITO_IRQ_DROP_CNT_EN
    for (int i = 0; i < 4 + 260; i++) cyc(1'b1, 4'd6, 32'h600 + 32'(i), '0);
    check_eq("tp7_sat", 32'(irq_drop_cnt[6]), 32'hFF);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'd0, 32'h0, 8'h40);
    check_eq("tp7_clr", 32'(irq_drop_cnt[6]), 32'h0);
`endif

    // random traffic: broad spread, then concentrated to force full queues
    for (int i = 0; i < 1500; i++) begin
      logic [3:0]    hid;
      logic [NH-1:0] a;
      hid = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      for (int h = 0; h < NH; h++) a[h] = ($urandom_range(0, 9) < 3);
      cyc(($urandom_range(0, 9) < 7), hid, $urandom, a);
    end
    for (int i = 0; i < 1500; i++) begin
      logic [NH-1:0] a;
      for (int h = 0; h < NH; h++) a[h] = ($urandom_range(0, 9) == 0);
      cyc(($urandom_range(0, 9) < 8), 4'($urandom_range(0, 2)), $urandom, a);
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 4'd0, 32'h0, '1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
